// File: rtl/pulse_stretch.sv
// Per-channel event-to-blink stretcher: each input rising edge yields a 2^T-cycle on pulse and a 2^G-cycle gap.
// Latency: Output rises after the edge that first samples the event; one queued blink per channel, extras pulse Dropped.
module pulse_stretch #(
  parameter int N = 1,
  parameter int T = 20,
  parameter int G = 20
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Input,
  output logic [N-1:0] Output,
  output logic [N-1:0] Busy,
  output logic [N-1:0] Dropped
);

  localparam int CW = (T > G) ? T : G;
  localparam logic [CW-1:0] ON_LAST  = CW'({T{1'b1}});
  localparam logic [CW-1:0] GAP_LAST = CW'({G{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [N-1:0] in_prev;

  // Reset to all ones so a line already high at release is not an event.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) in_prev <= '1;
    else       in_prev <= Input;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            drop_d;
    logic            evt;
    logic            out_q, busy_q, drop_q;

    assign evt = Input[i] & ~in_prev[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      drop_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (evt) state_d = ST_ON;
        end
        ST_ON: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ON_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
          if (evt) begin
            if (pend_q) drop_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
        ST_GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            // A fresh event on the exit edge replaces the pending one being consumed.
            if (pend_q) begin
              state_d = ST_ON;
              pend_d  = evt;
            end else if (evt) begin
              state_d = ST_ON;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (evt) begin
            if (pend_q) drop_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        out_q   <= (state_d == ST_ON);
        busy_q  <= (state_d != ST_IDLE) | pend_d;
        drop_q  <= drop_d;
      end
    end

    assign Output[i]  = out_q;
    assign Busy[i]    = busy_q;
    assign Dropped[i] = drop_q;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch (N=4, T=3, G=2): directed scenarios plus random traffic against a timestamp-based blink model.
module tb_pulse_stretch;

  localparam int N   = 4;
  localparam int T   = 3;
  localparam int G   = 2;
  localparam int ONC = 1 << T;
  localparam int GPC = 1 << G;

  logic         Clk;
  logic         Reset;
  logic [N-1:0] Input;
  logic [N-1:0] Output;
  logic [N-1:0] Busy;
  logic [N-1:0] Dropped;

  pulse_stretch #(.N(N), .T(T), .G(G)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Input   (Input),
    .Output  (Output),
    .Busy    (Busy),
    .Dropped (Dropped)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel remembers when its current blink started; everything else follows from arithmetic on that.
  int           tcnt;
  int           blink_start [N];
  bit           active [N];
  bit           pend [N];
  logic [N-1:0] m_prev;
  logic [N-1:0] exp_out, exp_busy, exp_drop;
  int           drop_seen;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      pend[i]   = 1'b0;
      blink_start[i] = 0;
    end
    m_prev   = '1;
    exp_out  = '0;
    exp_busy = '0;
    exp_drop = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] v);
    bit ev;
    tcnt++;
    exp_drop = '0;
    for (int i = 0; i < N; i++) begin
      ev = v[i] & ~m_prev[i];
      if (active[i] && tcnt == blink_start[i] + ONC + GPC) begin
        if (pend[i]) begin
          blink_start[i] = tcnt;
          pend[i] = ev;
        end else if (ev) begin
          blink_start[i] = tcnt;
        end else begin
          active[i] = 1'b0;
        end
      end else if (!active[i]) begin
        if (ev) begin
          active[i] = 1'b1;
          blink_start[i] = tcnt;
        end
      end else if (ev) begin
        if (pend[i]) exp_drop[i] = 1'b1;
        else         pend[i] = 1'b1;
      end
      exp_out[i]  = active[i] && (tcnt < blink_start[i] + ONC);
      exp_busy[i] = active[i] | pend[i];
    end
    m_prev = v;
  endtask

  task automatic step(input logic [N-1:0] v);
    Input = v;
    @(posedge Clk);
    model_edge(v);
    #1;
    chk("output",  32'(Output),  32'(exp_out));
    chk("busy",    32'(Busy),    32'(exp_busy));
    chk("dropped", 32'(Dropped), 32'(exp_drop));
    drop_seen += int'(Dropped[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  initial begin
    tcnt = 0;
    drop_seen = 0;
    Input = '0;
    Reset = 1'b1;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("rst_output",  32'(Output),  32'd0);
    chk("rst_busy",    32'(Busy),    32'd0);
    chk("rst_dropped", 32'(Dropped), 32'd0);
    #2 Reset = 1'b0;
    idle(3);

    // Single one-cycle pulse.
    step(4'b0001);
    chk("single_on_k", 32'(Output[0]), 32'd1);
    idle(7);
    chk("single_on_k7", 32'(Output[0]), 32'd1);
    step('0);
    chk("single_off_k8", 32'(Output[0]), 32'd0);
    idle(3);
    chk("single_busy_k11", 32'(Busy[0]), 32'd1);
    step('0);
    chk("single_busy_k12", 32'(Busy[0]), 32'd0);
    idle(4);

    // Level held high for 50 cycles is a single event.
    for (int i = 0; i < 50; i++) step(4'b0001);
    idle(16);

    // Pulses at k, k+2, k+4: one pending, one dropped.
    drop_seen = 0;
    step(4'b0001); step('0); step(4'b0001); step('0); step(4'b0001);
    idle(30);
    chk("queue_drop_cnt", 32'(drop_seen), 32'd1);

    // Event sampled on the final gap edge with nothing pending restarts directly.
    step(4'b0001);
    idle(11);
    step(4'b0001);
    chk("final_gap_restart", 32'(Output[0]), 32'd1);
    idle(24);

    // Reset mid-ON with pending set, input held high through release.
    step(4'b0001); step('0); step(4'b0001);
    Input = 4'b0001;
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_output", 32'(Output), 32'd0);
    chk("async_rst_busy",   32'(Busy),   32'd0);
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b0;
    for (int i = 0; i < 20; i++) step(4'b0001);
    step('0);
    step(4'b0001);
    chk("post_rst_blink", 32'(Output[0]), 32'd1);
    idle(16);

    // Independent channels 1 and 3, three cycles apart.
    step(4'b0010); step('0); step('0); step(4'b1000);
    chk("ch_indep_both_on", 32'(Output), 32'b1010);
    idle(20);

    // Random traffic: sparse pulses, then denser levels.
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = ($urandom_range(0, 99) < 12);
      step(v);
    end
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] v;
      for (int c = 0; c < N; c++)
        v[c] = ($urandom_range(0, 99) < 25) ? ~Input[c] : Input[c];
      step(v);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
